// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled framing FSM, RSR -> RDR transfer with sticky error flags.
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_SIZE   = 7,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    input  logic                 sample_tick,
    input  logic                 rd,
    output logic [DATA_SIZE-1:0] d_o,
    output logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_SIZE < 2 ||
        CLK_FREQ_HZ < BAUD_RATE * OVERSAMPLE) begin : g_cfg_check
        $error("uart_rx: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_SIZE-1:0]   r_rsr;
    logic [DATA_SIZE-1:0]   r_rdr;
    logic                   r_ready;
    logic                   r_ferr;
    logic                   r_oerr;
    logic                   w_rxs;
    logic                   w_bit_end;
    logic                   w_busy;
    logic                   w_shift;
    logic                   w_stop_sample;
    logic                   w_load;
    logic                   w_frame_bad;

    assign w_rxs     = r_sync2;
    assign w_bit_end = sample_tick && (r_cnt == CNT_END);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (sample_tick && !w_rxs) w_state_next = S_START;
            // Start bit is re-checked at its centre to reject line glitches.
            S_START:  if (sample_tick && r_cnt == CNT_MID)
                          w_state_next = w_rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (w_bit_end && r_idx == IDX_LAST) w_state_next = S_PARITY;
            S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`else
            S_DATA:   if (w_bit_end && r_idx == IDX_LAST) w_state_next = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy        = (r_state != S_IDLE);
        w_shift       = (r_state == S_DATA) && w_bit_end;
        w_stop_sample = (r_state == S_STOP) && w_bit_end;
        w_load        = w_stop_sample && w_rxs;
        w_frame_bad   = w_stop_sample && !w_rxs;
    end

    // Host handshake: rx_ready is the valid flag for d_o; rd acknowledges it and clears
    // every flag on the next edge, except that a load on the same edge wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rsr   <= '0;
            r_rdr   <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end else begin
            r_sync1 <= data_in;
            r_sync2 <= r_sync1;
            if (r_state != w_state_next || w_bit_end)
                r_cnt <= '0;
            else if (sample_tick && r_state != S_IDLE)
                r_cnt <= r_cnt + 1'b1;
            if (w_shift)
                r_idx <= r_idx + 1'b1;
            else if (r_state != S_DATA)
                r_idx <= '0;
            if (w_shift)
                r_rsr <= {w_rxs, r_rsr[DATA_SIZE-1:1]};
            if (w_load)
                r_rdr <= r_rsr;
            r_ready <= w_load | (r_ready & ~rd);
            r_oerr  <= ~rd & (r_oerr | (w_load & r_ready));
            r_ferr  <= w_frame_bad | (r_ferr & ~rd);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_perr;
    logic w_par_sample;

    assign w_par_sample = (r_state == S_PARITY) && w_bit_end;

    // r_par accumulates data bits and the parity bit; nonzero at stop means even parity failed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (r_state == S_START)
                r_par <= 1'b0;
            else if (w_shift || w_par_sample)
                r_par <= r_par ^ w_rxs;
            r_perr <= (w_stop_sample & r_par) | (r_perr & ~rd);
        end
    end

    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

    assign d_o         = r_rdr;
    assign rx_ready    = r_ready;
    assign rx_busy     = w_busy;
    assign frame_err   = r_ferr;
    assign overrun_err = r_oerr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx, checked against a frame-level model of the
// host-visible register and flag rules.
module tb_uart_rx;
    localparam int DW      = 7;
    localparam int BIT_CLK = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          data_in;
    logic          sample_tick;
    logic          rd;
    logic [DW-1:0] d_o;
    logic          rx_ready;
    logic          rx_busy;
    logic          frame_err;
    logic          overrun_err;
    logic          parity_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    logic          m_ready;
    logic          m_ferr;
    logic          m_oerr;
    logic          m_perr;

    uart_rx #(.DATA_SIZE(DW), .CLK_FREQ_HZ(50_000_000), .BAUD_RATE(9600), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .sample_tick(sample_tick), .rd(rd),
        .d_o(d_o), .rx_ready(rx_ready), .rx_busy(rx_busy), .frame_err(frame_err),
        .overrun_err(overrun_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 sample_tick = 1'b1;
            @(posedge clk);
            #1 sample_tick = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_dout();
        return (exp_q.size() == 0) ? '0 : exp_q[$];
    endfunction

    task automatic model_clear();
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_oerr  = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        chk({tag, ".d_o"},         32'(d_o),         32'(exp_dout()));
        chk({tag, ".rx_ready"},    32'(rx_ready),    32'(m_ready));
        chk({tag, ".frame_err"},   32'(frame_err),   32'(m_ferr));
        chk({tag, ".overrun_err"}, 32'(overrun_err), 32'(m_oerr));
        chk({tag, ".parity_err"},  32'(parity_err),  32'(m_perr));
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        step(BIT_CLK);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            data_in = w[i];
            step(BIT_CLK / 2);
            if (i == 2) begin
                @(negedge clk);
                chk("busy_mid_frame", 32'(rx_busy), 32'd1);
            end
            step(BIT_CLK / 2);
        end
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
        if ((^w) ^ par_b) m_perr = 1'b1;
`endif
        send_bit(stop_b);
        data_in = 1'b1;
        if (stop_b) begin
            if (m_ready) m_oerr = 1'b1;
            m_ready = 1'b1;
            exp_q.push_back(w);
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic do_rd();
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        model_clear();
    endtask

    initial begin
        logic          saw_busy;
        logic [DW-1:0] w;
        logic          stop_b;
        logic          par_b;

        reset   = 1'b1;
        data_in = 1'b1;
        rd      = 1'b0;
        model_clear();
        step(4);
        check_all("reset");
        chk("reset.rx_busy", 32'(rx_busy), 32'd0);
        reset = 1'b0;
        step(BIT_CLK);

        send_frame(7'h55, 1'b1, ^7'h55);
        check_all("frame_55");
        do_rd();
        @(negedge clk);
        chk("rd_clears_ready", 32'(rx_ready), 32'd0);

        send_frame(7'h12, 1'b1, ^7'h12);
        send_frame(7'h6B, 1'b1, ^7'h6B);
        check_all("overrun_6b");
        do_rd();
        check_all("overrun_rd");

        send_frame(7'h3C, 1'b0, ^7'h3C);
        step(BIT_CLK);
        check_all("frame_err_3c");
        do_rd();

        saw_busy = 1'b0;
        data_in  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rx_busy) saw_busy = 1'b1;
            @(posedge clk);
            #1;
            if (i == 15) data_in = 1'b1;
        end
        chk("glitch_busy_seen", 32'(saw_busy), 32'd1);
        chk("glitch_busy_end", 32'(rx_busy), 32'd0);
        check_all("glitch_flags");
        send_frame(7'h01, 1'b1, ^7'h01);
        check_all("after_glitch_01");

        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        data_in = 1'b1;
        exp_q.delete();
        model_clear();
        check_all("mid_frame_reset");
        chk("mid_frame_reset.busy", 32'(rx_busy), 32'd0);
        step(BIT_CLK * 2);
        send_frame(7'h2A, 1'b1, ^7'h2A);
        check_all("after_reset_2a");

`ifdef UART_RX_PARITY_EN
        do_rd();
        send_frame(7'h07, 1'b1, 1'b0);
        check_all("parity_bad_07");
        do_rd();
        send_frame(7'h07, 1'b1, 1'b1);
        check_all("parity_good_07");
`endif

        for (int n = 0; n < 12; n++) begin
            w      = DW'($urandom_range(0, (1 << DW) - 1));
            stop_b = ($urandom_range(0, 3) != 0);
            par_b  = (^w) ^ ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) do_rd();
            send_frame(w, stop_b, par_b);
            if (!stop_b || $urandom_range(0, 1) == 1) step(BIT_CLK);
            check_all($sformatf("rand_%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
